// File: rtl/riscv_core_mc_pkg.sv
// riscv_core_mc_pkg: shared types, opcodes and datapath helpers for the multicycle RV32I core
package riscv_core_mc_pkg;

    typedef enum logic [2:0] {S_BOOT, S_FETCH, S_EXEC, S_MEM, S_TRAP} state_t;

    // ALU codes are {alt, funct3}, so R/I-type decode maps straight onto them
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000, ALU_SLL = 4'b0001, ALU_SLT = 4'b0010, ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100, ALU_SRL = 4'b0101, ALU_OR  = 4'b0110, ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000, ALU_SRA = 4'b1101
    } alu_op_t;

    typedef enum logic [1:0] {SRCA_RS1, SRCA_PC, SRCA_ZERO} srca_t;
    typedef enum logic [1:0] {SRCB_RS2, SRCB_IMM_I, SRCB_IMM_S, SRCB_IMM_U} srcb_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef struct packed {
        logic    illegal;
        logic    gpr_we;
        logic    mem_req;
        logic    mem_we;
        logic    is_jal;
        logic    is_jalr;
        logic    is_branch;
        alu_op_t alu_op;
        srca_t   srca;
        srcb_t   srcb;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [31:0] ir);
        ctrl_t c;
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ir[14:12];
        f7 = ir[31:25];
        c = '0;
        case (ir[6:0])
            OP_LUI:    begin c.gpr_we = 1'b1; c.srca = SRCA_ZERO; c.srcb = SRCB_IMM_U; end
            OP_AUIPC:  begin c.gpr_we = 1'b1; c.srca = SRCA_PC; c.srcb = SRCB_IMM_U; end
            OP_JAL:    begin c.gpr_we = 1'b1; c.is_jal = 1'b1; end
            OP_JALR:   begin c.gpr_we = 1'b1; c.is_jalr = 1'b1; c.srcb = SRCB_IMM_I; c.illegal = f3 != 3'd0; end
            OP_BRANCH: begin c.is_branch = 1'b1; c.illegal = f3[2:1] == 2'b01; end
            OP_LOAD:   begin c.mem_req = 1'b1; c.srcb = SRCB_IMM_I; c.illegal = f3 == 3'd3 || f3[2:1] == 2'b11; end
            OP_STORE:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.srcb = SRCB_IMM_S; c.illegal = f3[2] || f3 == 3'd3; end
            OP_IMM: begin
                c.gpr_we = 1'b1;
                c.srcb = SRCB_IMM_I;
                c.alu_op = alu_op_t'({f3 == 3'd5 && f7[5], f3});
                c.illegal = (f3 == 3'd1 && f7 != 7'd0) || (f3 == 3'd5 && f7 != 7'd0 && f7 != 7'h20);
            end
            OP_REG: begin
                c.gpr_we = 1'b1;
                c.alu_op = alu_op_t'({f7[5] && (f3 == 3'd0 || f3 == 3'd5), f3});
                c.illegal = !(f7 == 7'd0 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: return {31'd0, a < b};
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return a + b;
        endcase
    endfunction

    // funct3[2:1] picks eq/lt/ltu, funct3[0] inverts the sense
    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic r;
        r = f3[2] ? (f3[1] ? a < b : $signed(a) < $signed(b)) : a == b;
        return r ^ f3[0];
    endfunction

endpackage

// File: rtl/riscv_core_mc_imm_gen.sv
// riscv_imm_gen: RV32I immediate extraction from the instruction register
// Ports: i_ir instruction bits [31:7]; o_imm_i/s/b/j/u sign-extended (U: upper) immediates
module riscv_imm_gen (
    input  logic [31:7] i_ir,
    output logic [31:0] o_imm_i,
    output logic [31:0] o_imm_s,
    output logic [31:0] o_imm_b,
    output logic [31:0] o_imm_j,
    output logic [31:0] o_imm_u
);
    assign o_imm_i = {{21{i_ir[31]}}, i_ir[30:20]};
    assign o_imm_s = {{21{i_ir[31]}}, i_ir[30:25], i_ir[11:7]};
    assign o_imm_b = {{20{i_ir[31]}}, i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
    assign o_imm_j = {{12{i_ir[31]}}, i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
    assign o_imm_u = {i_ir[31:12], 12'b0};
endmodule

// File: rtl/riscv_core_mc.sv
// riscv_core_mc: multicycle RV32I core with stallable instruction/data bus ports and trap handling
// Ports: clk_i/reset (sync, active-low); instr_* fetch bus; data_* load/store bus;
//        pc_o current PC; illegal_o trap pulse; retire_cnt_o committed count; debug_result_o last GPR write value
module riscv_core_mc
    import riscv_core_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h7600_0000,
    parameter logic [31:0] TRAP_PC  = 32'h7600_0100,
    parameter int          RETIRE_W = 32
) (
    input  logic                clk_i,
    input  logic                reset,
    output logic                instr_req_o,
    output logic [31:0]         instr_addr_o,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_ready_i,
    output logic                data_req_o,
    output logic                data_we_o,
    output logic [2:0]          data_size_o,
    output logic [31:0]         data_addr_o,
    output logic [31:0]         data_wdata_o,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_ready_i,
    output logic [31:0]         pc_o,
    output logic                illegal_o,
    output logic [RETIRE_W-1:0] retire_cnt_o,
    output logic [31:0]         debug_result_o
);
    state_t              r_state, w_next;
    logic [31:0]         r_pc, r_ir, r_debug;
    logic [31:0]         r_regs [32];
    logic [RETIRE_W-1:0] r_retire;
    ctrl_t               w_ctrl;
    logic [31:0]         w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic [31:0]         w_rs1, w_rs2, w_a, w_b, w_alu, w_pc4, w_target, w_next_pc, w_wdata;
    logic                w_redirect, w_misalign, w_exec_commit, w_mem_commit, w_we;

    riscv_imm_gen u_imm_gen (
        .i_ir    (r_ir[31:7]),
        .o_imm_i (w_imm_i),
        .o_imm_s (w_imm_s),
        .o_imm_b (w_imm_b),
        .o_imm_j (w_imm_j),
        .o_imm_u (w_imm_u)
    );

    assign w_ctrl = decode(r_ir);
    assign w_rs1  = r_regs[r_ir[19:15]];
    assign w_rs2  = r_regs[r_ir[24:20]];
    assign w_a    = w_ctrl.srca == SRCA_PC ? r_pc : w_ctrl.srca == SRCA_ZERO ? 32'd0 : w_rs1;
    assign w_b    = w_ctrl.srcb == SRCB_IMM_I ? w_imm_i : w_ctrl.srcb == SRCB_IMM_S ? w_imm_s :
                    w_ctrl.srcb == SRCB_IMM_U ? w_imm_u : w_rs2;
    assign w_alu  = alu(w_ctrl.alu_op, w_a, w_b);
    assign w_pc4  = r_pc + 32'd4;

    // jalr's ALU result is rs1+imm_I; bit 0 is dropped before the alignment check
    assign w_target   = w_ctrl.is_jalr ? {w_alu[31:1], 1'b0} : w_ctrl.is_jal ? r_pc + w_imm_j : r_pc + w_imm_b;
    assign w_redirect = w_ctrl.is_jal || w_ctrl.is_jalr || (w_ctrl.is_branch && br_taken(r_ir[14:12], w_rs1, w_rs2));
    assign w_misalign = w_redirect && w_target[1:0] != 2'b00;
    assign w_next_pc  = w_redirect ? w_target : w_pc4;

    assign w_exec_commit = r_state == S_EXEC && !w_ctrl.illegal && !w_misalign && !w_ctrl.mem_req;
    assign w_mem_commit  = r_state == S_MEM && data_ready_i;
    assign w_we          = (w_exec_commit && w_ctrl.gpr_we) || (w_mem_commit && !w_ctrl.mem_we);
    assign w_wdata       = r_state == S_MEM ? data_rdata_i : (w_ctrl.is_jal || w_ctrl.is_jalr) ? w_pc4 : w_alu;

    always_ff @(posedge clk_i) begin
        r_state <= !reset ? S_BOOT : w_next;
    end

    always_comb begin
        w_next = r_state == S_BOOT  ? S_FETCH :
                 r_state == S_FETCH ? (instr_ready_i ? S_EXEC : S_FETCH) :
                 r_state == S_EXEC  ? (w_ctrl.illegal || w_misalign ? S_TRAP : w_ctrl.mem_req ? S_MEM : S_FETCH) :
                 r_state == S_MEM   ? (data_ready_i ? S_FETCH : S_MEM) :
                 S_FETCH;
    end

    always_comb begin
        instr_req_o = r_state == S_FETCH;
        data_req_o  = r_state == S_MEM;
        illegal_o   = r_state == S_TRAP;
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_retire <= '0;
            r_debug  <= '0;
        end else begin
            if (r_state == S_FETCH && instr_ready_i) r_ir <= instr_rdata_i;
            r_pc <= w_exec_commit ? w_next_pc : w_mem_commit ? w_pc4 : r_state == S_TRAP ? TRAP_PC : r_pc;
            if (w_exec_commit || w_mem_commit) r_retire <= r_retire + RETIRE_W'(1);
            if (w_we) r_debug <= w_wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_we && r_ir[11:7] != 5'd0) begin
            r_regs[r_ir[11:7]] <= w_wdata;
        end
    end

    assign instr_addr_o   = r_pc;
    assign pc_o           = r_pc;
    assign data_we_o      = w_ctrl.mem_we;
    assign data_size_o    = r_ir[14:12];
    assign data_addr_o    = w_alu;
    assign data_wdata_o   = w_rs2;
    assign retire_cnt_o   = r_retire;
    assign debug_result_o = r_debug;
endmodule

// File: tb/tb_riscv_core_mc.sv
// tb_riscv_core_mc: table-driven program with bus-stall models and a commit scoreboard
module tb_riscv_core_mc;
    localparam logic [31:0] RPC = 32'h7600_0000;
    localparam logic [31:0] TPC = 32'h7600_0100;

    logic        clk_i = 1'b0, reset = 1'b0;
    logic        instr_req_o, instr_ready_i = 1'b0;
    logic [31:0] instr_addr_o, instr_rdata_i = '0;
    logic        data_req_o, data_we_o, data_ready_i = 1'b0;
    logic [2:0]  data_size_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i = '0;
    logic [31:0] pc_o, retire_cnt_o, debug_result_o;
    logic        illegal_o;

    always #5 clk_i = ~clk_i;

    riscv_core_mc #(.RESET_PC(RPC), .TRAP_PC(TPC), .RETIRE_W(32)) dut (
        .clk_i(clk_i), .reset(reset),
        .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_rdata_i(instr_rdata_i), .instr_ready_i(instr_ready_i),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_size_o(data_size_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_rdata_i(data_rdata_i), .data_ready_i(data_ready_i),
        .pc_o(pc_o), .illegal_o(illegal_o), .retire_cnt_o(retire_cnt_o),
        .debug_result_o(debug_result_o)
    );

    typedef struct {
        logic [31:0] instr;
        int          iwait;
        logic        mem;
        logic        we;
        logic [31:0] daddr, wdata, rdata;
        int          dwait;
        logic        trap;
        logic [31:0] pc, dbg;
    } vec_t;

    typedef struct {
        logic        trap;
        logic [31:0] ret, pc, dbg;
    } sb_t;

    vec_t        vecs [15];
    vec_t        post;
    sb_t         sb [$];
    sb_t         e;
    int          checks = 0, errors = 0;
    logic        mon_en = 1'b0;
    logic [31:0] last_ret = '0, exp_ret = '0, exp_fetch = RPC;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic wait_ireq();
        for (int k = 0; k < 20 && !instr_req_o; k++) @(negedge clk_i);
        chk("instr_req_seen", instr_req_o, 1);
    endtask

    task automatic wait_dreq();
        for (int k = 0; k < 20 && !data_req_o; k++) @(negedge clk_i);
        chk("data_req_seen", data_req_o, 1);
    endtask

    task automatic run_vec(input vec_t v);
        sb_t s;
        wait_ireq();
        chk("fetch_addr", instr_addr_o, exp_fetch);
        for (int k = 0; k < v.iwait; k++) begin
            @(negedge clk_i);
            chk("fetch_hold_req", instr_req_o, 1);
            chk("fetch_hold_addr", instr_addr_o, exp_fetch);
        end
        instr_rdata_i = v.instr;
        instr_ready_i = 1'b1;
        if (!v.trap) exp_ret++;
        s = '{v.trap, exp_ret, v.pc, v.dbg};
        sb.push_back(s);
        @(negedge clk_i);
        instr_ready_i = 1'b0;
        instr_rdata_i = '0;
        if (v.mem) begin
            wait_dreq();
            chk("data_addr", data_addr_o, v.daddr);
            chk("data_we", data_we_o, v.we);
            chk("data_size", data_size_o, 3'd2);
            if (v.we) chk("data_wdata", data_wdata_o, v.wdata);
            for (int k = 0; k < v.dwait; k++) begin
                @(negedge clk_i);
                chk("data_hold_req", data_req_o, 1);
                chk("data_hold_addr", data_addr_o, v.daddr);
            end
            data_rdata_i = v.rdata;
            data_ready_i = 1'b1;
            @(negedge clk_i);
            data_ready_i = 1'b0;
        end else begin
            @(negedge clk_i);
            chk("no_data_req", data_req_o, 0);
        end
        exp_fetch = v.trap ? TPC : v.pc;
    endtask

    always @(negedge clk_i) begin
        if (mon_en && (illegal_o || retire_cnt_o != last_ret)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_event", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ev_trap", illegal_o, e.trap);
                chk("ev_retire", retire_cnt_o, e.ret);
                chk("ev_dbg", debug_result_o, e.dbg);
                if (!e.trap) chk("ev_pc", pc_o, e.pc);
            end
        end
        last_ret = retire_cnt_o;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h00500093, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0004, 32'h0000_0005};
        vecs[1]  = '{32'h10000113, 4, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0008, 32'h0000_0100};
        vecs[2]  = '{32'h00412183, 0, 1, 0, 32'h104, 0, 32'hDEAD_BEEF, 3, 0, 32'h7600_000C, 32'hDEAD_BEEF};
        vecs[3]  = '{32'h00112023, 0, 1, 1, 32'h100, 32'h5, 32'h1234_5678, 0, 0, 32'h7600_0010, 32'hDEAD_BEEF};
        vecs[4]  = '{32'hFE000CE3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0008, 32'hDEAD_BEEF};
        vecs[5]  = '{32'h00118213, 1, 0, 0, 0, 0, 0, 0, 0, 32'h7600_000C, 32'hDEAD_BEF0};
        vecs[6]  = '{32'h760002B7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0010, 32'h7600_0000};
        vecs[7]  = '{32'h02128367, 2, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0020, 32'h7600_0014};
        vecs[8]  = '{32'h002003EF, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h7600_0014};
        vecs[9]  = '{32'h00000000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h7600_0014};
        vecs[10] = '{32'h00001417, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0104, 32'h7600_1100};
        vecs[11] = '{32'h00001463, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0108, 32'h7600_1100};
        vecs[12] = '{32'h402084B3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_010C, 32'hFFFF_FF05};
        vecs[13] = '{32'h00700013, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0110, 32'h0000_0007};
        vecs[14] = '{32'h00000533, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0114, 32'h0000_0000};
        post     = '{32'h000085B3, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7600_0004, 32'h0000_0000};

        repeat (3) @(negedge clk_i);
        chk("rst_pc", pc_o, RPC);
        chk("rst_retire", retire_cnt_o, 0);
        chk("rst_dbg", debug_result_o, 0);
        chk("rst_ireq", instr_req_o, 0);
        chk("rst_dreq", data_req_o, 0);
        chk("rst_illegal", illegal_o, 0);
        reset  = 1'b1;
        mon_en = 1'b1;
        @(negedge clk_i);
        chk("first_ireq", instr_req_o, 1);
        chk("first_iaddr", instr_addr_o, RPC);

        for (int i = 0; i < 15; i++) run_vec(vecs[i]);
        @(negedge clk_i);
        chk("sb_drained", sb.size(), 0);

        wait_ireq();
        chk("mm_fetch_addr", instr_addr_o, 32'h7600_0114);
        instr_rdata_i = 32'h00412183;
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        instr_ready_i = 1'b0;
        wait_dreq();
        chk("mm_daddr", data_addr_o, 32'h104);
        @(negedge clk_i);
        mon_en = 1'b0;
        reset  = 1'b0;
        @(negedge clk_i);
        chk("mm_dreq", data_req_o, 0);
        chk("mm_pc", pc_o, RPC);
        chk("mm_retire", retire_cnt_o, 0);
        chk("mm_dbg", debug_result_o, 0);
        chk("mm_ireq", instr_req_o, 0);
        reset = 1'b1;
        sb.delete();
        exp_ret   = '0;
        exp_fetch = RPC;
        @(negedge clk_i);
        chk("mm_refetch_req", instr_req_o, 1);
        chk("mm_refetch_addr", instr_addr_o, RPC);
        mon_en = 1'b1;
        run_vec(post);
        @(negedge clk_i);
        chk("sb_final_drained", sb.size(), 0);
        chk("final_retire", retire_cnt_o, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/riscv_core_mc.md
Name: riscv_core_mc

Overview:
- Multicycle successor to the single-cycle RV32I processor top.
- Replaces the zero-latency instruction and data memories with req/ready bus ports to external memories, so either memory may stall for any number of cycles.
- Adds a configurable reset/trap vector, a trap on illegal instructions and misaligned jump targets, and a retired-instruction counter.
- Instantiates the existing decoder, register file and ALU.

Parameters:
- RESET_PC, 32'h7600_0000: PC loaded on reset.
- TRAP_PC, 32'h7600_0100: PC loaded on any trap.
- RETIRE_W, 32: width of the retire counter (8..64).

Ports:
- clk_i  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- instr_req_o  out  1  fetch request.
- instr_addr_o  out  32  fetch address; equals pc.
- instr_rdata_i  in  32  fetched word; valid when instr_ready_i=1.
- instr_ready_i  in  1  fetch complete.
- data_req_o  out  1  load/store request.
- data_we_o  out  1  1=store, 0=load.
- data_size_o  out  3  funct3 size/sign code from the decoder.
- data_addr_o  out  32  ALU result.
- data_wdata_o  out  32  rs2 value.
- data_rdata_i  in  32  load data; already sized and extended by memory.
- data_ready_i  in  1  access complete.
- pc_o  out  32  current PC.
- illegal_o  out  1  one-cycle pulse when a trap is taken.
- retire_cnt_o  out  RETIRE_W  count of committed instructions.
- debug_result_o  out  32  last value written to the register file.

Behaviour:
- FSM states: BOOT, FETCH, EXEC, MEM, TRAP.
- Reset (reset==0 at a rising edge):
  - state<=BOOT, pc<=RESET_PC, IR<=0.
  - retire_cnt_o<=0, debug_result_o<=0.
  - Register file is cleared.
  - This applies from any state, including mid-fetch or mid-MEM; the outstanding request is abandoned.
- BOOT:
  - All req outputs 0, illegal_o 0.
  - Next state is FETCH unconditionally.
- FETCH:
  - instr_req_o=1 and instr_addr_o=pc, held stable until instr_ready_i=1.
  - On the edge where ready=1: IR<=instr_rdata_i, go to EXEC.
  - Ready may be high in the first request cycle, giving a 1-cycle fetch.
- EXEC: decode IR, drive the ALU operand muxes, resolve next PC.
  - Priority 1, illegal instruction: go to TRAP. No register write, no data_req.
  - Priority 2, misaligned target: jal, jalr or a taken branch whose target[1:0]!=0 goes to TRAP.
  - Priority 3, memory op (mem_req): go to MEM with no register write. Operands stay stable because IR is held.
  - Otherwise: commit and return to FETCH.
    - Register write when gpr_we is set (x0 write is discarded by the register file).
    - pc updated; retire_cnt_o increments.
- MEM:
  - data_req_o=1; data_addr_o, data_wdata_o, data_we_o and data_size_o held stable until data_ready_i=1.
  - On the ready edge: commit, pc<=pc+4, go to FETCH.
  - A load writes rd<=data_rdata_i; a store writes nothing.
- TRAP:
  - illegal_o=1 for exactly this cycle; pc<=TRAP_PC; go to FETCH.
  - retire_cnt_o does not increment.
- Next-PC rules:
  - jalr: (rs1+imm_I) with bit 0 cleared.
  - jal: pc+imm_J.
  - Taken branch: pc+imm_B.
  - Otherwise: pc+4.
  - All arithmetic is modulo 2^32; wrap-around is silent.
- Immediate formats:
  - imm_U = {IR[31:12],12'b0}.
  - jal/jalr link value is pc+4.
- Latency with zero-wait memories:
  - ALU/branch/jump: 2 cycles.
  - load/store: 3 cycles.
  - trap: 3 cycles (FETCH, EXEC, TRAP).
- retire_cnt_o wraps from all-ones to 0.
- debug_result_o updates only on a committing register write, including x0 attempts (it records the value presented).

Decomposition:
- Shared defines, alongside the existing ALU opcode defines: FSM state encodings, and the ALU operand-mux select codes for srcA/srcB (the srcB imm_U select is now the corrected 12-zero form).
- One natural sub-module, riscv_imm_gen: combinational generation of imm_I, imm_S, imm_B, imm_J and imm_U from IR.

Test Plan:
- Reset release, zero-wait memories: first instr_addr_o=32'h7600_0000 one cycle after BOOT; then addi x1,x0,5 -> x1=5, debug_result_o=5, retire_cnt_o=1, pc=32'h7600_0004 after 2 cycles.
- Fetch stall: instr_ready_i held low 4 cycles -> instr_req_o and instr_addr_o stable throughout; instruction commits on cycle 6.
- Load stall: x2=32'h100, lw x3,4(x2), data_ready_i after 3 cycles with rdata 32'hDEAD_BEEF:
  - data_addr_o=32'h104 for all 3 cycles.
  - x3=32'hDEAD_BEEF; exactly one retire.
- Store: sw x1,0(x2) -> data_we_o=1, data_wdata_o=5; no register-file write; debug_result_o unchanged.
- Branch and jump:
  - beq taken with imm_B=-8 from pc 32'h7600_0010 -> pc=32'h7600_0008.
  - jalr with target 32'h7600_0021 -> pc=32'h7600_0020, link=pc+4.
  - jal with imm_J=+2 -> TRAP, pc=TRAP_PC.
- Illegal instruction 32'h0000_0000 -> illegal_o one-cycle pulse; no data_req; pc=32'h7600_0100; retire_cnt_o unchanged.
- Reset asserted mid-MEM -> data_req_o=0 after BOOT entry, pc=RESET_PC, retire_cnt_o=0.
